// File: rtl/prog_ctr_if.sv
// -----------------------------------------------------------------------------
// prog_ctr_if
//   Fetch-control bundle between the sequencer/decoder and the program counter.
//
//   Start        launch request for the next stored program (level)
//   BranchRelEn  current instruction is a conditional relative branch
//   ALU_flag     branch condition from the ALU
//   Target       two's-complement relative branch offset
//   ProgCtr      registered instruction-fetch index (drives the ROM address)
//
//   master: the side that drives the controls and reads ProgCtr
//   slave : the program counter itself
// -----------------------------------------------------------------------------
interface prog_ctr_if #(
    parameter int W = 10
);
    logic         Start;
    logic         BranchRelEn;
    logic         ALU_flag;
    logic [W-1:0] Target;
    logic [W-1:0] ProgCtr;

    modport master (
        output Start,
        output BranchRelEn,
        output ALU_flag,
        output Target,
        input  ProgCtr
    );

    modport slave (
        input  Start,
        input  BranchRelEn,
        input  ALU_flag,
        input  Target,
        output ProgCtr
    );
endinterface

// File: rtl/prog_ctr.sv
// -----------------------------------------------------------------------------
// prog_ctr
//   Program counter for the instruction-fetch stage. Each rising edge of Start
//   launches the next of three stored programs (1 -> 2 -> 3 -> 1 ...) at its
//   base address. While a program runs the counter advances by one per cycle,
//   or adds the signed Target offset when BranchRelEn and ALU_flag are both 1.
//   Arithmetic wraps modulo 2^W. Start always has priority over branch/step.
//
//   Clk    rising-edge clock
//   Reset  asynchronous, active-low reset
//   bus    prog_ctr_if.slave: Start, BranchRelEn, ALU_flag, Target in;
//          ProgCtr out (purely registered)
// -----------------------------------------------------------------------------
module prog_ctr #(
    parameter int           W          = 10,
    parameter logic [W-1:0] PROG1_BASE = 10'd0,
    parameter logic [W-1:0] PROG2_BASE = 10'd200,
    parameter logic [W-1:0] PROG3_BASE = 10'd500
) (
    input  logic       Clk,
    input  logic       Reset,
    prog_ctr_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [W-1:0] PC_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state,  stateNext;
    logic [1:0]   sel,    selNext;     // 0 = no program launched yet
    logic [W-1:0] pcReg,  pcNext;
    logic         startQ;
    logic         startRise;
    logic         takeBranch;

    assign startRise  = bus.Start & ~startQ;
    assign takeBranch = bus.BranchRelEn & bus.ALU_flag;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            sel    <= 2'd0;
            pcReg  <= '0;
            startQ <= 1'b0;
        end else begin
            state  <= stateNext;
            sel    <= selNext;
            pcReg  <= pcNext;
            startQ <= bus.Start;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        selNext   = sel;
        pcNext    = pcReg;

        if (startRise) begin
            // Program selector cycles 1 -> 2 -> 3 -> 1; 0 only exists out of reset.
            selNext   = (sel == 2'd3) ? 2'd1 : sel + 2'd1;
            stateNext = LOAD;
            case (selNext)
                2'd1:    pcNext = PROG1_BASE;
                2'd2:    pcNext = PROG2_BASE;
                default: pcNext = PROG3_BASE;
            endcase
        end else if (bus.Start) begin
            // Start held: park at the base address, no further program advance.
            stateNext = LOAD;
        end else if (state != IDLE) begin
            stateNext = RUN;
            // Target is already W bits wide, so a W-bit add is the
            // sign-extended relative branch modulo 2^W.
            if (takeBranch) begin
                pcNext = pcReg + bus.Target;
            end else begin
                pcNext = pcReg + PC_ONE;
            end
        end
    end

    assign bus.ProgCtr = pcReg;

endmodule

// File: tb/tb_prog_ctr.sv
// -----------------------------------------------------------------------------
// tb_prog_ctr
//   Directed, self-checking bench for prog_ctr. Inputs change 1 time unit
//   after each rising edge, and ProgCtr is sampled at the same point.
// -----------------------------------------------------------------------------
module tb_prog_ctr;

    localparam int W = 10;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    prog_ctr_if #(.W(W)) bus ();

    prog_ctr #(.W(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] expected);
        checks++;
        assert (bus.ProgCtr === expected)
        else begin
            failures++;
            $error("FAIL %s: ProgCtr=%0d expected=%0d", tag, bus.ProgCtr, expected);
        end
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        Reset           = 1'b0;
        bus.Start       = 1'b0;
        bus.BranchRelEn = 1'b0;
        bus.ALU_flag    = 1'b0;
        bus.Target      = '0;

        // Reset, then idle
        step();
        check("reset", 10'd0);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_hold", 10'd0);
        end

        // Program selection sequence
        pulse_start();
        check("prog1_base", 10'd0);
        bus.Start = 1'b0;
        step();
        step();
        check("prog1_run2", 10'd2);
        pulse_start();
        check("prog2_base", 10'd200);
        bus.Start = 1'b0;
        step();
        check("prog2_run1", 10'd201);
        pulse_start();
        check("prog3_base", 10'd500);
        bus.Start = 1'b0;
        step();
        pulse_start();
        check("wrap_prog1", 10'd0);
        bus.Start = 1'b0;
        step();
        check("wrap_prog1_run", 10'd1);

        // Start held for 4 edges: one advance only (to program 2)
        bus.Start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("held_base", 10'd200);
        end
        bus.Start = 1'b0;
        step();
        check("held_release", 10'd201);
        pulse_start();
        check("held_single_adv", 10'd500);

        // Back to program 1 and run to 3
        bus.Start = 1'b0;
        step();
        pulse_start();
        check("prog1_again", 10'd0);
        bus.Start = 1'b0;
        step();
        step();
        step();
        check("run_to_3", 10'd3);

        // Relative branch
        bus.BranchRelEn = 1'b1;
        bus.ALU_flag    = 1'b1;
        bus.Target      = 10'd60;
        step();
        check("branch_taken", 10'd63);
        bus.BranchRelEn = 1'b0;
        step();
        check("branch_cleared", 10'd64);

        // Branch gating
        bus.BranchRelEn = 1'b1;
        bus.ALU_flag    = 1'b0;
        step();
        check("gate_flag0", 10'd65);
        bus.BranchRelEn = 1'b0;
        bus.ALU_flag    = 1'b1;
        step();
        check("gate_en0", 10'd66);

        // Negative branches: 66 + (-61) = 5, then 5 + (-10) = 1019
        bus.BranchRelEn = 1'b1;
        bus.ALU_flag    = 1'b1;
        bus.Target      = 10'h3C3;
        step();
        check("branch_back_5", 10'd5);
        bus.Target = 10'h3F6;
        step();
        check("branch_neg_wrap", 10'd1019);

        // Increment wrap 1023 -> 0
        bus.BranchRelEn = 1'b0;
        bus.ALU_flag    = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pc_1023", 10'd1023);
        step();
        check("inc_wrap", 10'd0);

        // Start wins over a qualified branch
        bus.BranchRelEn = 1'b1;
        bus.ALU_flag    = 1'b1;
        bus.Target      = 10'd100;
        pulse_start();
        check("start_priority", 10'd200);
        bus.Start       = 1'b0;
        bus.BranchRelEn = 1'b0;
        bus.ALU_flag    = 1'b0;
        step();
        pulse_start();
        check("prog3_for_reset", 10'd500);
        bus.Start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pc_505", 10'd505);

        // Asynchronous reset between edges
        #3;
        Reset = 1'b0;
        #1;
        check("async_reset", 10'd0);
        step();
        check("reset_held", 10'd0);
        Reset = 1'b1;
        pulse_start();
        check("post_reset_prog1", 10'd0);
        bus.Start = 1'b0;
        step();
        check("post_reset_run", 10'd1);

        // Start held through reset release counts as a rise
        bus.Start = 1'b1;
        Reset     = 1'b0;
        step();
        Reset = 1'b1;
        step();
        check("start_thru_release", 10'd0);
        step();
        check("start_thru_hold", 10'd0);
        bus.Start = 1'b0;
        step();
        check("start_thru_run", 10'd1);
        pulse_start();
        check("start_thru_next", 10'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
